// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream: drains a FIFO read port into a registered valid/ready stream.
// A 2-entry skid buffer absorbs the FIFO read latency (0 or 1 cycle) so the
// stream sustains one word per cycle, and a line counter tags the last word of
// each image line.
module fifo_rd_stream #(
  parameter int DATA_WIDTH = 32,
  parameter int RD_LATENCY = 0,
  parameter int LINE_LEN   = 224,
  parameter int CNT_W      = 10
) (
  input  logic                  rd_clk,
  input  logic                  rd_rst_n,
  output logic                  fifo_rd_en,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data,
  input  logic                  fifo_empty,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  output logic [CNT_W-1:0]      word_cnt
);

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(LINE_LEN - 1);

  logic [DATA_WIDTH-1:0] head_reg, head_next;
  logic [DATA_WIDTH-1:0] tail_reg, tail_next;
  logic [1:0]            buf_cnt_reg, buf_cnt_next;
  logic [CNT_W-1:0]      word_cnt_reg, word_cnt_next;
  logic                  inflight;
  logic                  push;
  logic                  pop;
  logic                  rd_en;
  logic [1:0]            occupancy;

  assign pop       = (buf_cnt_reg != 2'd0) & m_ready;
  // Words already owed to the buffer: stored ones plus a read still in flight.
  assign occupancy = buf_cnt_reg + {1'b0, inflight};
  // Issue a read only if the word is guaranteed a slot when it lands:
  // (occupancy - pop) < 2 is the same as "occupancy < 2, or a pop frees one".
  // Gated by reset so no read is lost while the buffer is being cleared.
  assign rd_en     = rd_rst_n & ~fifo_empty & (pop | (occupancy < 2'd2));

  if (RD_LATENCY == 0) begin : g_lat0
    // Data comes back in the same cycle, so a read is captured immediately.
    assign inflight = 1'b0;
    assign push     = rd_en;
  end else begin : g_lat1
    logic inflight_reg;

    // Remember a read issued this cycle; its data is captured on the next one.
    always_ff @(posedge rd_clk or negedge rd_rst_n) begin
      if (!rd_rst_n) begin
        inflight_reg <= 1'b0;
      end else begin
        inflight_reg <= rd_en;
      end
    end

    assign inflight = inflight_reg;
    assign push     = inflight_reg;
  end

  // Skid buffer update: head is the oldest word, tail the younger one.
  always_comb begin
    head_next    = head_reg;
    tail_next    = tail_reg;
    buf_cnt_next = buf_cnt_reg;
    case ({push, pop})
      2'b10: begin
        buf_cnt_next = buf_cnt_reg + 2'd1;
        if (buf_cnt_reg == 2'd0) begin
          head_next = fifo_rd_data;
        end else begin
          tail_next = fifo_rd_data;
        end
      end
      2'b01: begin
        buf_cnt_next = buf_cnt_reg - 2'd1;
        head_next    = tail_reg;
      end
      2'b11: begin
        // Count is unchanged; the new word lands behind whatever remains.
        if (buf_cnt_reg == 2'd1) begin
          head_next = fifo_rd_data;
        end else begin
          head_next = tail_reg;
          tail_next = fifo_rd_data;
        end
      end
      default: begin
      end
    endcase
  end

  // Position of the head word within its image line, advanced per pop.
  always_comb begin
    word_cnt_next = word_cnt_reg;
    if (pop) begin
      if (word_cnt_reg == LAST_IDX) begin
        word_cnt_next = '0;
      end else begin
        word_cnt_next = word_cnt_reg + CNT_W'(1);
      end
    end
  end

  // State registers; reset discards buffered words and restarts the line.
  always_ff @(posedge rd_clk or negedge rd_rst_n) begin
    if (!rd_rst_n) begin
      head_reg     <= '0;
      tail_reg     <= '0;
      buf_cnt_reg  <= 2'd0;
      word_cnt_reg <= '0;
    end else begin
      head_reg     <= head_next;
      tail_reg     <= tail_next;
      buf_cnt_reg  <= buf_cnt_next;
      word_cnt_reg <= word_cnt_next;
    end
  end

  assign fifo_rd_en = rd_en;
  assign m_valid    = (buf_cnt_reg != 2'd0);
  assign m_data     = head_reg;
  assign m_last     = (buf_cnt_reg != 2'd0) & (word_cnt_reg == LAST_IDX);
  assign word_cnt   = word_cnt_reg;

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Bench for fifo_rd_stream: two instances (read latency 0 and 1) share one
// clock, reset, m_ready and write stream, each fed by its own FIFO model.
module tb_fifo_rd_stream;

  localparam int DW    = 32;
  localparam int LL    = 224;
  localparam int CW    = 10;
  localparam int DEPTH = 8192;

  logic clk = 1'b0;
  logic rst_n;
  logic m_ready;

  logic          fifo_rd_en_w   [2];
  logic [DW-1:0] fifo_rd_data_w [2];
  logic          fifo_empty_w   [2];
  logic          m_valid_w      [2];
  logic [DW-1:0] m_data_w       [2];
  logic          m_last_w       [2];
  logic [CW-1:0] word_cnt_w     [2];

  // FIFO model: one write pointer shared by both lanes, a read pointer per lane.
  logic [DW-1:0] fmem [2][DEPTH];
  logic [12:0]   wp;
  logic [12:0]   rp [2];
  logic [DW-1:0] rdq [2];

  // Abstract stream model per lane, all counted since the last reset.
  int            rd_cnt  [2];
  int            pop_cnt [2];
  logic [12:0]   pop_idx [2];
  logic          last_rd [2];
  int            done_cyc[2];
  int            last_n  [2];
  logic [DW-1:0] lastd   [2][16];

  int cyc;
  int n_tests;
  int n_fail;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40) $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  for (genvar gi = 0; gi < 2; gi++) begin : g_lane
    fifo_rd_stream #(
      .DATA_WIDTH(DW),
      .RD_LATENCY(gi),
      .LINE_LEN  (LL),
      .CNT_W     (CW)
    ) dut (
      .rd_clk      (clk),
      .rd_rst_n    (rst_n),
      .fifo_rd_en  (fifo_rd_en_w[gi]),
      .fifo_rd_data(fifo_rd_data_w[gi]),
      .fifo_empty  (fifo_empty_w[gi]),
      .m_valid     (m_valid_w[gi]),
      .m_ready     (m_ready),
      .m_data      (m_data_w[gi]),
      .m_last      (m_last_w[gi]),
      .word_cnt    (word_cnt_w[gi])
    );

    assign fifo_empty_w[gi] = (rp[gi] == wp);
    if (gi == 0) begin : g_rd0
      assign fifo_rd_data_w[gi] = fmem[gi][rp[gi]];
    end else begin : g_rd1
      assign fifo_rd_data_w[gi] = rdq[gi];
    end

    // FIFO read port plus the read/pop bookkeeping of the model.
    always @(posedge clk) begin
      if (!rst_n) begin
        rp[gi]      <= wp;
        pop_idx[gi] <= wp;
        rd_cnt[gi]  <= 0;
        pop_cnt[gi] <= 0;
        last_rd[gi] <= 1'b0;
      end else begin
        last_rd[gi] <= fifo_rd_en_w[gi];
        if (fifo_rd_en_w[gi]) begin
          rdq[gi]    <= fmem[gi][rp[gi]];
          rp[gi]     <= rp[gi] + 13'd1;
          rd_cnt[gi] <= rd_cnt[gi] + 1;
        end
        if (m_valid_w[gi] && m_ready) begin
          pop_cnt[gi] <= pop_cnt[gi] + 1;
          pop_idx[gi] <= pop_idx[gi] + 13'd1;
          if (pop_cnt[gi] + 1 == 448) done_cyc[gi] <= cyc;
          if (m_last_w[gi]) begin
            lastd[gi][last_n[gi] % 16] <= m_data_w[gi];
            last_n[gi] <= last_n[gi] + 1;
          end
        end
      end
    end

    // Per-cycle comparison against the model, sampled just after the falling edge.
    always begin : cmp
      int   occ;
      int   avail;
      logic ev;
      logic epop;
      @(negedge clk);
      #1;
      if (rst_n) begin
        occ   = rd_cnt[gi] - pop_cnt[gi];
        avail = occ - ((gi == 1 && last_rd[gi]) ? 1 : 0);
        ev    = (avail > 0);
        epop  = ev && m_ready;
        chk($sformatf("L%0d_valid", gi), m_valid_w[gi], ev);
        chk($sformatf("L%0d_occ_le2", gi), (occ <= 2), 1);
        chk($sformatf("L%0d_rd_en", gi), fifo_rd_en_w[gi],
            (!fifo_empty_w[gi] && (occ - (epop ? 1 : 0)) < 2));
        chk($sformatf("L%0d_rd_while_empty", gi), (fifo_rd_en_w[gi] && fifo_empty_w[gi]), 0);
        if (ev) begin
          chk($sformatf("L%0d_data", gi), m_data_w[gi], fmem[gi][pop_idx[gi]]);
          chk($sformatf("L%0d_word_cnt", gi), word_cnt_w[gi], pop_cnt[gi] % LL);
          chk($sformatf("L%0d_last", gi), m_last_w[gi], (pop_cnt[gi] % LL) == LL - 1);
        end
      end
    end
  end

  task automatic push_word(input logic [DW-1:0] d);
    for (int l = 0; l < 2; l++) fmem[l][wp] = d;
    wp = wp + 13'd1;
  endtask

  function automatic bit drained();
    for (int l = 0; l < 2; l++)
      if (rp[l] != wp || rd_cnt[l] != pop_cnt[l]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic wait_drain(input int limit);
    int g;
    g = 0;
    @(negedge clk);
    while (!drained() && g < limit) begin
      @(negedge clk);
      g++;
    end
    chk("drain_timeout", drained(), 1);
  endtask

  task automatic chk_zero(input string tag);
    for (int l = 0; l < 2; l++) begin
      chk($sformatf("%s_L%0d_rd_en", tag, l), fifo_rd_en_w[l], 0);
      chk($sformatf("%s_L%0d_valid", tag, l), m_valid_w[l], 0);
      chk($sformatf("%s_L%0d_data", tag, l), m_data_w[l], 0);
      chk($sformatf("%s_L%0d_last", tag, l), m_last_w[l], 0);
      chk($sformatf("%s_L%0d_wcnt", tag, l), word_cnt_w[l], 0);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int start;
    int base_last [2];
    int rd_base   [2];
    int pop_base  [2];
    int nw;

    rst_n   = 1'b1;
    m_ready = 1'b0;
    wp      = '0;
    #1 rst_n = 1'b0;

    // Reset state: outputs clear and no read even with a non-empty FIFO.
    @(negedge clk);
    push_word(32'hDEAD);
    #1;
    chk_zero("reset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    $display("[TB] reset values checked");

    // 448-word stream at full rate; m_last on words 223 and 447.
    m_ready = 1'b1;
    start   = cyc;
    for (int l = 0; l < 2; l++) base_last[l] = last_n[l];
    for (int i = 0; i < 448; i++) push_word(DW'(i));
    wait_drain(1000);
    for (int l = 0; l < 2; l++) begin
      chk($sformatf("stream_L%0d_cycles", l), done_cyc[l] - start, 448 + l);
      chk($sformatf("stream_L%0d_nlast", l), last_n[l] - base_last[l], 2);
      chk($sformatf("stream_L%0d_last0", l), lastd[l][base_last[l] % 16], 223);
      chk($sformatf("stream_L%0d_last1", l), lastd[l][(base_last[l] + 1) % 16], 447);
    end
    $display("[TB] 448-word stream done");

    // Single word: read pulse, then valid 1 (latency 0) or 2 (latency 1) cycles later.
    @(negedge clk);
    push_word(32'hA5A5A5A5);
    #1;
    chk("single_L0_rd_en", fifo_rd_en_w[0], 1);
    chk("single_L1_rd_en", fifo_rd_en_w[1], 1);
    @(negedge clk); #1;
    chk("single_L0_valid_c1", m_valid_w[0], 1);
    chk("single_L0_data", m_data_w[0], 32'hA5A5A5A5);
    chk("single_L1_valid_c1", m_valid_w[1], 0);
    chk("single_L1_rd_en_c1", fifo_rd_en_w[1], 0);
    @(negedge clk); #1;
    chk("single_L0_valid_c2", m_valid_w[0], 0);
    chk("single_L1_valid_c2", m_valid_w[1], 1);
    chk("single_L1_data", m_data_w[1], 32'hA5A5A5A5);
    @(negedge clk); #1;
    chk("single_L1_valid_c3", m_valid_w[1], 0);
    $display("[TB] single word done");

    // Backpressure: exactly two reads, head held, then ten gap-free pops.
    @(negedge clk);
    m_ready = 1'b0;
    for (int l = 0; l < 2; l++) begin
      rd_base[l]  = rd_cnt[l];
      pop_base[l] = pop_cnt[l];
    end
    for (int i = 0; i < 10; i++) push_word(32'h100 + DW'(i));
    for (int c = 0; c < 20; c++) begin
      @(negedge clk); #1;
      if (c >= 2)
        for (int l = 0; l < 2; l++) chk($sformatf("bp_L%0d_hold", l), m_data_w[l], 32'h100);
    end
    for (int l = 0; l < 2; l++) begin
      chk($sformatf("bp_L%0d_reads", l), rd_cnt[l] - rd_base[l], 2);
      chk($sformatf("bp_L%0d_valid", l), m_valid_w[l], 1);
    end
    @(negedge clk);
    m_ready = 1'b1;
    repeat (10) @(negedge clk);
    #1;
    for (int l = 0; l < 2; l++) chk($sformatf("bp_L%0d_pops", l), pop_cnt[l] - pop_base[l], 10);
    $display("[TB] backpressure done");

    // Random fill and random m_ready, 5000 words.
    nw = 0;
    while (nw < 5000) begin
      @(negedge clk);
      m_ready = $urandom_range(0, 1) == 1;
      if ($urandom_range(0, 99) < (((cyc / 128) % 2 == 1) ? 80 : 20)) begin
        push_word($urandom);
        nw++;
      end
    end
    m_ready = 1'b1;
    wait_drain(200);
    $display("[TB] random 5000 words done");

    // Reset mid-line with full buffer at word_cnt 100.
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 100; i++) push_word(32'h4000 + DW'(i));
    wait_drain(500);
    @(negedge clk);
    m_ready = 1'b0;
    for (int i = 0; i < 10; i++) push_word(32'h4100 + DW'(i));
    repeat (4) @(negedge clk);
    #1;
    for (int l = 0; l < 2; l++) begin
      chk($sformatf("mid_L%0d_wcnt", l), word_cnt_w[l], 100);
      chk($sformatf("mid_L%0d_valid", l), m_valid_w[l], 1);
      chk($sformatf("mid_L%0d_data", l), m_data_w[l], 32'h4100);
    end
    #1 rst_n = 1'b0;
    #1;
    chk_zero("async_rst");
    @(negedge clk);
    @(negedge clk);
    rst_n   = 1'b1;
    m_ready = 1'b1;
    for (int l = 0; l < 2; l++) base_last[l] = last_n[l];
    for (int i = 0; i < 230; i++) push_word(32'h5000 + DW'(i));
    wait_drain(500);
    for (int l = 0; l < 2; l++) begin
      chk($sformatf("rst_L%0d_nlast", l), last_n[l] - base_last[l], 1);
      chk($sformatf("rst_L%0d_first_last", l), lastd[l][base_last[l] % 16], 32'h5000 + 223);
    end
    $display("[TB] mid-line reset done");

    // FIFO empties right after a read: the word still arrives, no extra reads.
    @(negedge clk);
    m_ready = 1'b0;
    for (int l = 0; l < 2; l++) rd_base[l] = rd_cnt[l];
    push_word(32'hBEEF);
    repeat (5) @(negedge clk);
    #1;
    for (int l = 0; l < 2; l++) begin
      chk($sformatf("empty_L%0d_valid", l), m_valid_w[l], 1);
      chk($sformatf("empty_L%0d_data", l), m_data_w[l], 32'hBEEF);
      chk($sformatf("empty_L%0d_reads", l), rd_cnt[l] - rd_base[l], 1);
    end
    @(negedge clk);
    m_ready = 1'b1;
    wait_drain(50);
    $display("[TB] empty-after-read done");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
